stopwatch_run_controller: RTL and testbench
===========================================

# stopwatch_run_controller

Sequencing controller for the min/sec/stopwatch datapath. It turns debounced single-cycle button pulses into the stopwatch core's `run_stop` and `clear` controls, captures lap times, and selects which count goes to the FND controller (stopwatch, MM.SS clock, or HH.MM clock). It drives the status LEDs and the FND idle-animation enable. It sits between the `my_btn_debounce` instances and the stopwatch core / `minsec_stop_fnd_controller`.

## Interface
- `LAP_HOLD_CYCLES`, default 300_000_000: clock cycles a frozen lap value stays displayed before auto-release (3 s at 100 MHz).
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `btn_run` in 1: debounced one-cycle pulse; start/stop.
- `btn_clear` in 1: debounced one-cycle pulse; clear when stopped, lap when running.
- `btn_mode` in 1: debounced one-cycle pulse; cycles the display mode.
- `hour_count` in 5: 0..23.
- `min_count` in 6: 0..59.
- `sec_count` in 6: 0..59.
- `stopwatch_count` in 14: 0..9999, shown as SS.CC.
- `run_stop` out 1: 1 means the core counts.
- `clear` out 1: one-cycle clear pulse to the core.
- `seg_data` out 14: binary value 0..9999 for the FND controller.
- `anim_mode` out 1: FND idle animation enable.
- `led` out 16: status.

## Operation
- The block has a 4-state FSM: IDLE, RUN, STOP, LAP.
- Display mode is a separate 3-value register that cycles SW → MMSS → HHMM → SW.
- FSM transitions are evaluated on the cycle a pulse is high:
  - IDLE: `btn_run` → RUN. `btn_clear` → `clear` pulse, stay IDLE.
  - RUN: `btn_run` → STOP. `btn_clear` → LAP. On that same cycle: capture `stopwatch_count` into `lap_reg`, increment `lap_cnt` (4 bit, saturates at 15), and load the hold timer with `LAP_HOLD_CYCLES-1`.
  - LAP: `btn_clear` → RUN (manual release). Timer reaching 0 → RUN. `btn_run` → STOP, and the lap display is discarded.
  - STOP: `btn_run` → RUN. `btn_clear` → `clear` pulse, `lap_cnt`←0, go to IDLE.
- If `btn_run` and `btn_clear` are high in the same cycle, `btn_clear` is acted on and `btn_run` is ignored.
- `btn_mode` is independent of the FSM and is processed in the same cycle as any other pulse.
- `run_stop` = 1 in RUN and LAP; the core keeps counting during LAP.
- `seg_data` source:
  - LAP with mode SW: `lap_reg`.
  - Otherwise, mode SW: `stopwatch_count`.
  - MMSS: `min_count*100 + sec_count` (max 5999).
  - HHMM: `hour_count*100 + min_count` (max 2359).
  - Multiply-by-100 is done as shift-add in 14 bits; overflow is impossible for in-range inputs.
- `anim_mode` = 1 only when the state is IDLE and the mode is SW.
- `led` bit assignment:
  - [0] IDLE, [1] RUN, [2] STOP, [3] LAP (one-hot).
  - [4] SW, [5] MMSS, [6] HHMM (one-hot).
  - [7] 0.
  - [11:8] `lap_cnt`.
  - [15:12] 0.
- Reset:
  - State IDLE, mode SW, `lap_reg`=0, `lap_cnt`=0, timer=0.
  - Outputs: `run_stop`=0, `clear`=0, `seg_data`=0, `anim_mode`=1, `led`=16'h0011.

## Timing
- All outputs are registered. A pulse in cycle N is reflected on `run_stop`, `led`, and `anim_mode` in cycle N+1.
- `clear` is high for exactly cycle N+1 only, for a clear-qualified pulse in cycle N.
- `seg_data` follows its selected source with 1-cycle latency. While in LAP with mode SW it is constant at the value `stopwatch_count` had in the capture cycle.
- Hold timer:
  - Decrements once per cycle in LAP.
  - Expiry is an exact count: a lap captured in cycle N has its state leave LAP in cycle N+`LAP_HOLD_CYCLES`, visible on outputs at N+`LAP_HOLD_CYCLES`+1.
  - The timer does not run outside LAP.
- Re-lap: a `btn_clear` pulse in RUN directly after an auto-release captures a new lap normally.
- Mode change during LAP: the lap is still held by the FSM. `seg_data` shows the clock while the mode is MMSS or HHMM, and shows `lap_reg` again on return to SW if the state is still LAP.
- `reset` asserted mid-operation wins over any same-cycle pulse. Outputs reach their reset values on the next edge.

## Test plan
- Reset, then idle 10 cycles → `led`=16'h0011, `anim_mode`=1, `run_stop`=0, `seg_data`=0.
- `btn_run` pulse at cycle N → `run_stop`=1 at N+1, `led`=16'h0012, `anim_mode`=0. A second `btn_run` → `led`=16'h0014, `run_stop`=0.
- `LAP_HOLD_CYCLES`=20, state RUN, `stopwatch_count`=1234 at the `btn_clear` pulse, input then ramps:
  - `seg_data`=1234 held for 20 cycles.
  - `led`[11:8]=1, `led`[3]=1, `run_stop` stays 1.
  - Then `seg_data` tracks the live count again.
- In STOP with `lap_cnt`=3, `btn_clear` → `clear` high exactly 1 cycle, `led`[11:8]=0, state IDLE. The same-cycle `btn_run`+`btn_clear` pulse in STOP gives the identical result.
- Sixteen laps → `lap_cnt` saturates at 15.
- Mode cycling with `hour_count`=23, `min_count`=59, `sec_count`=58:
  - First `btn_mode` → `seg_data`=5958, `led`[5]=1.
  - Second → 2359, `led`[6]=1.
  - Third → back to SW.

Source files
------------

// File: rtl/stopwatch_run_controller_if.sv
// ---------------------------------------------------------------------------
// stopwatch_run_controller_if
//   Bundles the button pulses, the live time counts and the controller outputs
//   between the debouncers/timekeeping core and the run controller.
//
//   master : the surrounding system (drives buttons and counts, reads controls)
//   slave  : stopwatch_run_controller
//
//   btn_run / btn_clear / btn_mode : one-cycle debounced pulses
//   hour_count / min_count / sec_count : wall clock, 0..23 / 0..59 / 0..59
//   stopwatch_count : 0..9999 (SS.CC)
//   run_stop, clear  : stopwatch core controls
//   seg_data         : binary value 0..9999 for the FND controller
//   anim_mode        : FND idle animation enable
//   led              : status LEDs
// ---------------------------------------------------------------------------
interface stopwatch_run_controller_if;
    logic        btn_run;
    logic        btn_clear;
    logic        btn_mode;
    logic [4:0]  hour_count;
    logic [5:0]  min_count;
    logic [5:0]  sec_count;
    logic [13:0] stopwatch_count;
    logic        run_stop;
    logic        clear;
    logic [13:0] seg_data;
    logic        anim_mode;
    logic [15:0] led;

    modport master (
        output btn_run, btn_clear, btn_mode,
        output hour_count, min_count, sec_count, stopwatch_count,
        input  run_stop, clear, seg_data, anim_mode, led
    );

    modport slave (
        input  btn_run, btn_clear, btn_mode,
        input  hour_count, min_count, sec_count, stopwatch_count,
        output run_stop, clear, seg_data, anim_mode, led
    );
endinterface

// File: rtl/stopwatch_run_controller.sv
// ---------------------------------------------------------------------------
// stopwatch_run_controller
//   Turns debounced button pulses into stopwatch run/clear controls, captures
//   lap times with a timed auto-release, and selects the value shown on the
//   FND (stopwatch, MM.SS clock or HH.MM clock). All outputs are registered.
//
//   Parameters
//     LAP_HOLD_CYCLES : cycles a captured lap stays frozen on the display
//   Ports
//     clk   : system clock
//     reset : synchronous, active-high
//     bus   : stopwatch_run_controller_if.slave (buttons, counts, outputs)
// ---------------------------------------------------------------------------
module stopwatch_run_controller #(
    parameter int unsigned LAP_HOLD_CYCLES = 300_000_000
) (
    input  logic                        clk,
    input  logic                        reset,
    stopwatch_run_controller_if.slave   bus
);

    // The timer only ever holds 0..LAP_HOLD_CYCLES-1.
    localparam int unsigned TW = (LAP_HOLD_CYCLES > 1) ? $clog2(LAP_HOLD_CYCLES) : 1;
    localparam logic [TW-1:0] HOLD_LOAD = TW'(LAP_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2,
        S_LAP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        M_SW   = 2'd0,
        M_MMSS = 2'd1,
        M_HHMM = 2'd2
    } mode_t;

    state_t        state_q, state_d;
    mode_t         mode_q,  mode_d;
    logic [13:0]   lap_reg_q, lap_reg_d;
    logic [3:0]    lap_cnt_q, lap_cnt_d;
    logic [TW-1:0] timer_q,   timer_d;

    logic          run_stop_q, run_stop_d;
    logic          clear_q,    clear_d;
    logic [13:0]   seg_q,      seg_d;
    logic          anim_q,     anim_d;
    logic [15:0]   led_q,      led_d;

    logic [13:0]   mmss_val;
    logic [13:0]   hhmm_val;

    // x*100 = x*64 + x*32 + x*4; in-range inputs stay below 2^14.
    function automatic logic [13:0] mul100(input logic [5:0] x);
        logic [13:0] w;
        w = 14'(x);
        return (w << 6) + (w << 5) + (w << 2);
    endfunction

    assign mmss_val = mul100(bus.min_count) + 14'(bus.sec_count);
    assign hhmm_val = mul100({1'b0, bus.hour_count}) + 14'(bus.min_count);

    // Next-state and next-output logic. Outputs are derived from the next
    // state/mode so that a pulse in cycle N shows up on the outputs in N+1.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        lap_reg_d = lap_reg_q;
        lap_cnt_d = lap_cnt_q;
        timer_d   = timer_q;
        clear_d   = 1'b0;

        // btn_clear always takes priority over btn_run.
        unique case (state_q)
            S_IDLE: begin
                if (bus.btn_clear)    clear_d = 1'b1;
                else if (bus.btn_run) state_d = S_RUN;
            end
            S_RUN: begin
                if (bus.btn_clear) begin
                    state_d   = S_LAP;
                    lap_reg_d = bus.stopwatch_count;
                    timer_d   = HOLD_LOAD;
                    if (lap_cnt_q != 4'hF) lap_cnt_d = lap_cnt_q + 4'd1;
                end else if (bus.btn_run) begin
                    state_d = S_STOP;
                end
            end
            S_LAP: begin
                if (timer_q != '0) timer_d = timer_q - TW'(1);
                // A user stop beats a same-cycle expiry.
                if (bus.btn_clear)     state_d = S_RUN;
                else if (bus.btn_run)  state_d = S_STOP;
                else if (timer_q == '0) state_d = S_RUN;
            end
            S_STOP: begin
                if (bus.btn_clear) begin
                    clear_d   = 1'b1;
                    lap_cnt_d = 4'd0;
                    state_d   = S_IDLE;
                end else if (bus.btn_run) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.btn_mode) begin
            unique case (mode_q)
                M_SW:    mode_d = M_MMSS;
                M_MMSS:  mode_d = M_HHMM;
                default: mode_d = M_SW;
            endcase
        end

        unique case (mode_d)
            M_SW:    seg_d = (state_d == S_LAP) ? lap_reg_d : bus.stopwatch_count;
            M_MMSS:  seg_d = mmss_val;
            default: seg_d = hhmm_val;
        endcase

        run_stop_d = (state_d == S_RUN) || (state_d == S_LAP);
        anim_d     = (state_d == S_IDLE) && (mode_d == M_SW);

        led_d       = '0;
        led_d[0]    = (state_d == S_IDLE);
        led_d[1]    = (state_d == S_RUN);
        led_d[2]    = (state_d == S_STOP);
        led_d[3]    = (state_d == S_LAP);
        led_d[4]    = (mode_d == M_SW);
        led_d[5]    = (mode_d == M_MMSS);
        led_d[6]    = (mode_d == M_HHMM);
        led_d[11:8] = lap_cnt_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mode_q     <= M_SW;
            lap_reg_q  <= '0;
            lap_cnt_q  <= '0;
            timer_q    <= '0;
            run_stop_q <= 1'b0;
            clear_q    <= 1'b0;
            seg_q      <= '0;
            anim_q     <= 1'b1;
            led_q      <= 16'h0011;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            lap_reg_q  <= lap_reg_d;
            lap_cnt_q  <= lap_cnt_d;
            timer_q    <= timer_d;
            run_stop_q <= run_stop_d;
            clear_q    <= clear_d;
            seg_q      <= seg_d;
            anim_q     <= anim_d;
            led_q      <= led_d;
        end
    end

    assign bus.run_stop  = run_stop_q;
    assign bus.clear     = clear_q;
    assign bus.seg_data  = seg_q;
    assign bus.anim_mode = anim_q;
    assign bus.led       = led_q;

endmodule

// File: tb/tb_stopwatch_run_controller.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_run_controller
//   Directed scenarios followed by randomized button/count traffic. Every
//   cycle the outputs are compared against a behavioural model that tracks
//   the controller phase, the display mode, the lap count and the absolute
//   cycle at which a held lap releases.
// ---------------------------------------------------------------------------
module tb_stopwatch_run_controller;
    localparam int HOLD = 20;
    localparam int PH_IDLE = 0, PH_RUN = 1, PH_STOP = 2, PH_LAP = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stopwatch_run_controller_if bus();

    stopwatch_run_controller #(.LAP_HOLD_CYCLES(HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // stimulus values held for the next cycle
    logic        rst_v;
    int          hr_v, mn_v, sc_v, sw_v;
    int          cyc_n = 0;

    // model
    int m_phase, m_mode, m_lap_val, m_laps, m_release_at;
    int e_seg, e_clear;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                      tag, got, got, exp, exp, cyc_n);
    endtask

    task automatic model_step(input bit r, input bit c, input bit m, input bit rs, input int cur);
        e_clear = 0;
        if (rs) begin
            m_phase = PH_IDLE; m_mode = 0; m_lap_val = 0; m_laps = 0;
            e_seg = 0;
            return;
        end
        case (m_phase)
            PH_IDLE: if (c) e_clear = 1; else if (r) m_phase = PH_RUN;
            PH_RUN: begin
                if (c) begin
                    m_phase      = PH_LAP;
                    m_lap_val    = sw_v;
                    m_laps       = (m_laps < 15) ? m_laps + 1 : 15;
                    m_release_at = cur + HOLD;
                end else if (r) m_phase = PH_STOP;
            end
            PH_LAP: begin
                if (c)                      m_phase = PH_RUN;
                else if (r)                 m_phase = PH_STOP;
                else if (cur == m_release_at) m_phase = PH_RUN;
            end
            default: begin
                if (c) begin e_clear = 1; m_laps = 0; m_phase = PH_IDLE; end
                else if (r) m_phase = PH_RUN;
            end
        endcase
        if (m) m_mode = (m_mode + 1) % 3;
        if (m_mode == 0)      e_seg = (m_phase == PH_LAP) ? m_lap_val : sw_v;
        else if (m_mode == 1) e_seg = mn_v * 100 + sc_v;
        else                  e_seg = hr_v * 100 + mn_v;
    endtask

    // One clock: apply inputs, let the edge happen, update model, compare.
    task automatic cyc(input bit r, input bit c, input bit m);
        int exp_led;
        @(negedge clk);
        reset               = rst_v;
        bus.btn_run         = r;
        bus.btn_clear       = c;
        bus.btn_mode        = m;
        bus.hour_count      = 5'(hr_v);
        bus.min_count       = 6'(mn_v);
        bus.sec_count       = 6'(sc_v);
        bus.stopwatch_count = 14'(sw_v);
        @(posedge clk);
        #1;
        model_step(r, c, m, rst_v, cyc_n);
        exp_led = rst_v ? 32'h11 : ((1 << m_phase) | (1 << (4 + m_mode)) | (m_laps << 8));
        chk("run_stop",  32'(bus.run_stop),  32'((m_phase == PH_RUN || m_phase == PH_LAP) ? 1 : 0));
        chk("clear",     32'(bus.clear),     32'(e_clear));
        chk("seg_data",  32'(bus.seg_data),  32'(e_seg));
        chk("anim_mode", 32'(bus.anim_mode), 32'((m_phase == PH_IDLE && m_mode == 0) ? 1 : 0));
        chk("led",       32'(bus.led),       32'(exp_led));
        cyc_n++;
    endtask

    initial begin
        reset = 1'b1;
        bus.btn_run = 0; bus.btn_clear = 0; bus.btn_mode = 0;
        bus.hour_count = 0; bus.min_count = 0; bus.sec_count = 0; bus.stopwatch_count = 0;
        rst_v = 1; hr_v = 0; mn_v = 0; sc_v = 0; sw_v = 0;
        m_phase = PH_IDLE; m_mode = 0; m_lap_val = 0; m_laps = 0; m_release_at = 0;

        // reset, then idle
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        rst_v = 0;
        sw_v  = 77;
        repeat (10) cyc(0, 0, 0);
        chk("idle_led",  32'(bus.led), 32'h0011);
        chk("idle_anim", 32'(bus.anim_mode), 32'd1);
        chk("idle_run",  32'(bus.run_stop), 32'd0);
        sw_v = 0;
        cyc(0, 0, 0);
        chk("idle_seg",  32'(bus.seg_data), 32'd0);

        // start / stop
        cyc(1, 0, 0);
        chk("start_led", 32'(bus.led), 32'h0012);
        chk("start_run", 32'(bus.run_stop), 32'd1);
        chk("start_anim", 32'(bus.anim_mode), 32'd0);
        cyc(1, 0, 0);
        chk("stop_led", 32'(bus.led), 32'h0014);
        chk("stop_run", 32'(bus.run_stop), 32'd0);

        // lap with auto-release after HOLD cycles
        cyc(1, 0, 0);
        sw_v = 1234;
        cyc(0, 1, 0);
        chk("lap_seg",  32'(bus.seg_data), 32'd1234);
        chk("lap_cnt",  32'(bus.led[11:8]), 32'd1);
        chk("lap_led3", 32'(bus.led[3]), 32'd1);
        for (int k = 0; k < HOLD - 1; k++) begin
            sw_v = 1235 + k;
            cyc(0, 0, 0);
            chk("lap_hold_seg", 32'(bus.seg_data), 32'd1234);
            chk("lap_hold_run", 32'(bus.run_stop), 32'd1);
        end
        sw_v = 5000;
        cyc(0, 0, 0);
        chk("release_seg",  32'(bus.seg_data), 32'd5000);
        chk("release_led3", 32'(bus.led[3]), 32'd0);
        chk("release_led1", 32'(bus.led[1]), 32'd1);

        // two manual laps -> 3, stop, clear
        repeat (2) begin cyc(0, 1, 0); cyc(0, 1, 0); end
        cyc(1, 0, 0);
        chk("stop3_cnt", 32'(bus.led[11:8]), 32'd3);
        cyc(0, 1, 0);
        chk("clr_pulse", 32'(bus.clear), 32'd1);
        chk("clr_led",   32'(bus.led), 32'h0011);
        cyc(0, 0, 0);
        chk("clr_once",  32'(bus.clear), 32'd0);

        // same scenario with run+clear together in STOP
        cyc(1, 0, 0);
        repeat (3) begin cyc(0, 1, 0); cyc(0, 1, 0); end
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        chk("rc_pulse", 32'(bus.clear), 32'd1);
        chk("rc_led",   32'(bus.led), 32'h0011);
        cyc(0, 0, 0);
        chk("rc_once",  32'(bus.clear), 32'd0);

        // lap counter saturation
        cyc(1, 0, 0);
        repeat (16) begin cyc(0, 1, 0); cyc(0, 1, 0); end
        chk("sat_cnt", 32'(bus.led[11:8]), 32'd15);
        cyc(1, 0, 0);
        cyc(0, 1, 0);

        // display mode cycling
        hr_v = 23; mn_v = 59; sc_v = 58; sw_v = 4321;
        cyc(0, 0, 1);
        chk("mmss_seg", 32'(bus.seg_data), 32'd5958);
        chk("mmss_led", 32'(bus.led[5]), 32'd1);
        cyc(0, 0, 1);
        chk("hhmm_seg", 32'(bus.seg_data), 32'd2359);
        chk("hhmm_led", 32'(bus.led[6]), 32'd1);
        cyc(0, 0, 1);
        chk("sw_led",   32'(bus.led[4]), 32'd1);
        chk("sw_seg",   32'(bus.seg_data), 32'd4321);

        // randomized traffic, alternating dense and sparse clear pulses
        for (int i = 0; i < 4000; i++) begin
            int pc;
            bit r, c, m;
            pc    = ((i / 500) % 2 == 1) ? 7 : 60;
            rst_v = ($urandom_range(0, 399) == 0);
            r     = ($urandom_range(0, 9) == 0);
            c     = ($urandom_range(0, pc) == 0);
            m     = ($urandom_range(0, 11) == 0);
            hr_v  = $urandom_range(0, 23);
            mn_v  = $urandom_range(0, 59);
            sc_v  = $urandom_range(0, 59);
            sw_v  = $urandom_range(0, 9999);
            cyc(r, c, m);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
